// File: rtl/mem_march_tester.sv
// BIST master for a 1-cycle-latency memory: two write/read-back passes over every
// address with a seeded pattern (true, then inverted), reporting errors and the first failing address.
module mem_march_tester #(
  parameter int unsigned           ADDR_WIDTH = 3,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    wr_en,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ADDR_WIDTH+1:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int unsigned          ERR_WIDTH = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  // Expected word for address a in pass ph
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic ph);
    logic [DATA_WIDTH-1:0] w;
    w = DATA_WIDTH'(a) ^ SEED;
    return ph ? ~w : w;
  endfunction

  state_t                  state, state_n;
  logic                    phase, phase_n;
  logic [ADDR_WIDTH-1:0]   a_prev, a_prev_n;
  logic                    cmp_valid, cmp_valid_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic                    wr_en_n, rd_en_n;
  logic [DATA_WIDTH-1:0]   wr_data_n;
  logic                    busy_n, done_n, pass_n;
  logic [ERR_WIDTH-1:0]    err_cnt_n;
  logic [ADDR_WIDTH-1:0]   first_err_addr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      phase          <= 1'b0;
      a_prev         <= '0;
      cmp_valid      <= 1'b0;
      addr           <= '0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
      rd_en          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      phase          <= phase_n;
      a_prev         <= a_prev_n;
      cmp_valid      <= cmp_valid_n;
      addr           <= addr_n;
      wr_en          <= wr_en_n;
      wr_data        <= wr_data_n;
      rd_en          <= rd_en_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_cnt        <= err_cnt_n;
      first_err_addr <= first_err_addr_n;
    end
  end

  always_comb begin
    state_n          = state;
    phase_n          = phase;
    a_prev_n         = addr;
    cmp_valid_n      = rd_en;
    addr_n           = addr;
    wr_en_n          = 1'b0;
    wr_data_n        = '0;
    rd_en_n          = 1'b0;
    busy_n           = busy;
    done_n           = done;
    pass_n           = pass;
    err_cnt_n        = err_cnt;
    first_err_addr_n = first_err_addr;

    // Compare stage: rd_data answers the read issued one cycle earlier
    if (cmp_valid && (rd_data != pattern(a_prev, phase))) begin
      if (err_cnt != ERR_MAX) err_cnt_n = err_cnt + 1'b1;
      if (err_cnt == '0)      first_err_addr_n = a_prev;
    end

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n          = S_WR;
          phase_n          = 1'b0;
          addr_n           = '0;
          err_cnt_n        = '0;
          first_err_addr_n = '0;
          done_n           = 1'b0;
          pass_n           = 1'b0;
          busy_n           = 1'b1;
          wr_en_n          = 1'b1;
          wr_data_n        = pattern('0, 1'b0);
        end
      end
      S_WR: begin
        if (addr == LAST_ADDR) begin
          state_n = S_RD;
          addr_n  = '0;
          rd_en_n = 1'b1;
        end else begin
          addr_n    = addr + 1'b1;
          wr_en_n   = 1'b1;
          wr_data_n = pattern(ADDR_WIDTH'(addr + 1'b1), phase);
        end
      end
      S_RD: begin
        if (addr == LAST_ADDR) begin
          state_n = S_DRAIN;
          addr_n  = '0;
        end else begin
          addr_n  = addr + 1'b1;
          rd_en_n = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!phase) begin
          state_n   = S_WR;
          phase_n   = 1'b1;
          addr_n    = '0;
          wr_en_n   = 1'b1;
          wr_data_n = pattern('0, 1'b1);
        end else begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_cnt_n == '0);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_march_tester.sv
// Self-checking bench for mem_march_tester: table vectors, hand sequences and randomized
// read-fault injection against an arithmetic reference model of the two-pass test.
module tb_mem_march_tester;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [2:0] first_err_addr;

  always #5 clk = ~clk;

  mem_march_tester #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory model with per-pass, per-address read corruption
  logic [7:0] mem [8];
  logic [7:0] rd_q;
  logic [7:0] masks [2][8];
  bit         ign;
  int         rdc;
  int         wr_n;
  int         wr_a [32];
  int         wr_d [32];
  bit         overlap;

  assign rd_data = rd_q;

  always @(posedge clk) begin
    if (start && !busy && !rst) begin
      rdc     <= 0;
      wr_n    <= 0;
      overlap <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[addr] <= wr_data;
        if (wr_n < 32) begin
          wr_a[wr_n] <= int'(addr);
          wr_d[wr_n] <= int'(wr_data);
          wr_n       <= wr_n + 1;
        end
      end
      if (rd_en) begin
        rd_q <= (ign ? 8'hFF : mem[addr]) ^ masks[(rdc >= 8) ? 1 : 0][addr];
        rdc  <= rdc + 1;
      end
      if (wr_en && rd_en) overlap <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_word(input int i, input int p);
    int x;
    x = (i & 255) ^ 'hA5;
    return p ? (~x & 255) : x;
  endfunction

  // Reference: walk both passes, count words that come back different from what was written
  task automatic model(output int e_err, output int e_first, output int e_pass);
    e_err = 0; e_first = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) begin
        int v;
        v = (ign ? 255 : exp_word(i, p)) ^ int'(masks[p][i]);
        if (v != exp_word(i, p)) begin
          if (e_err == 0) e_first = i;
          if (e_err < 31) e_err++;
        end
      end
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  task automatic clear_masks();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) masks[p][i] = 8'h00;
  endtask

  // Pulse (or hold) start and count busy cycles until done
  task automatic run_test(input string tag, input bit hold, input bit chk_clear);
    int cyc = 0;
    bit fin = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge clk);
      if (k == 0 && chk_clear)
        check({tag, " restart clears"}, {done, err_cnt, busy}, {1'b0, 5'd0, 1'b1});
      if (!hold) start = 1'b0;
      if (busy) cyc++;
      else if (cyc > 0) fin = 1;
    end
    start = 1'b0;
    check({tag, " busy cycles"}, cyc, 34);
  endtask

  task automatic check_results(input string tag, input int e_err, input int e_first, input int e_pass);
    int bad = 0;
    check({tag, " done"}, int'(done), 1);
    check({tag, " pass"}, int'(pass), e_pass);
    check({tag, " err_cnt"}, int'(err_cnt), e_err);
    check({tag, " first_err_addr"}, int'(first_err_addr), e_first);
    if (wr_n != 16) bad = 1;
    else
      for (int k = 0; k < 16; k++)
        if (wr_a[k] != k % 8 || wr_d[k] != exp_word(k % 8, k / 8)) bad++;
    check({tag, " write trace"}, bad, 0);
    check({tag, " strobe overlap"}, int'(overlap), 0);
  endtask

  typedef struct {
    bit   ign;
    logic [7:0] fmask;
    int   faddr;
    int   fpass;
    int   e_err;
    int   e_first;
    int   e_pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int e_err, e_first, e_pass, cyc;
    bit strobe_seen;

    tbl[0] = '{1'b0, 8'h00, 0, 0,  0, 0, 1};   // good memory
    tbl[1] = '{1'b0, 8'h01, 5, 0,  1, 5, 0};   // bit0 flip at addr 5, pass 0
    tbl[2] = '{1'b1, 8'h00, 0, 0, 16, 0, 0};   // writes ignored, reads 8'hFF
    tbl[3] = '{1'b0, 8'h80, 7, 1,  1, 7, 0};   // last read of second pass
    tbl[4] = '{1'b0, 8'h10, 0, 0,  1, 0, 0};   // first address fails

    ign = 1'b0; clear_masks();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {addr, wr_en, rd_en, busy, done, pass, err_cnt, first_err_addr},
          0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset busy", int'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      ign = tbl[v].ign;
      clear_masks();
      masks[tbl[v].fpass][tbl[v].faddr] = tbl[v].fmask;
      run_test(tag, 1'b0, 1'b0);
      check_results(tag, tbl[v].e_err, tbl[v].e_first, tbl[v].e_pass);
      if (v == 0) begin
        check("wr pass0 addr3", (wr_n == 16) ? wr_d[3] : -1, 'hA6);
        check("wr pass1 addr3", (wr_n == 16) ? wr_d[11] : -1, 'h59);
      end
    end

    // Reset on the 10th busy cycle aborts immediately and silences the strobes
    ign = 1'b0; clear_masks();
    @(negedge clk); start = 1'b1;
    cyc = 0;
    for (int k = 0; k < 50 && cyc < 10; k++) begin
      @(negedge clk); start = 1'b0;
      if (busy) cyc++;
    end
    check("busy before reset", cyc, 10);
    rst = 1'b1;
    #1;
    check("reset abort", {busy, wr_en, rd_en, done}, 0);
    strobe_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en || rd_en || busy) strobe_seen = 1;
    end
    check("no strobes in reset", int'(strobe_seen), 0);
    rst = 1'b0;
    run_test("post-reset", 1'b0, 1'b0);
    check_results("post-reset", 0, 0, 1);

    // Start held for the whole test, then a restart from DONE with a clean memory
    clear_masks();
    masks[0][2] = 8'h40;
    masks[1][6] = 8'h02;
    run_test("held start", 1'b1, 1'b0);
    check_results("held start", 2, 2, 0);
    @(negedge clk);
    check("held start no restart", {busy, done}, {1'b0, 1'b1});
    clear_masks();
    run_test("restart", 1'b0, 1'b1);
    check_results("restart", 0, 0, 1);

    // Randomized read faults against the reference model
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("rand%0d", r);
      ign = ($urandom_range(0, 4) == 0);
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < 8; i++)
          masks[p][i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      model(e_err, e_first, e_pass);
      run_test(tag, 1'b0, 1'b0);
      check_results(tag, e_err, e_first, e_pass);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
